// File: rtl/pipe_regs.sv
// Multi-stage valid/ready register pipeline with bubble collapsing and synchronous flush.
// Define PIPE_REGS_OCC_EN to add the registered occupancy output.
module pipe_regs #(
   parameter int WIDTH = 64,
   parameter int LANES = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data [LANES-1:0],
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data [LANES-1:0],
   input  logic             out_ready
`ifdef PIPE_REGS_OCC_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

   // Handshake: a transfer happens on a rising edge where valid & ready are both
   // high; valid never waits for ready, and ready may depend on valid downstream.

   logic [DEPTH-1:0] valid_q;
   logic [WIDTH-1:0] data_q [DEPTH-1:0][LANES-1:0];
   logic [DEPTH-1:0] adv;
   logic             adv_c;

   // A stage may advance if it is empty or the stage after it is advancing.
   always_comb begin
      adv_c = !valid_q[DEPTH-1] | out_ready;
      adv[DEPTH-1] = adv_c;
      for (int k = DEPTH - 2; k >= 0; k--) begin
         adv_c  = !valid_q[k] | adv_c;
         adv[k] = adv_c;
      end
   end

   assign in_ready  = adv[0] & !flush;
   assign out_valid = valid_q[DEPTH-1] & !flush;
   assign out_data  = data_q[DEPTH-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            for (int l = 0; l < LANES; l++) begin
               data_q[k][l] <= '0;
            end
         end
      end else if (flush) begin
         valid_q <= '0;
      end else begin
         if (adv[0]) begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
               data_q[0] <= in_data;
            end
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (adv[k]) begin
               valid_q[k] <= valid_q[k-1];
               if (valid_q[k-1]) begin
                  data_q[k] <= data_q[k-1];
               end
            end
         end
      end
   end

`ifdef PIPE_REGS_OCC_EN
   localparam int OW = $clog2(DEPTH + 1);

   logic          in_xfer;
   logic          out_xfer;
   logic [OW-1:0] occ_q;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   // Tracks popcount(valid_q) without an adder tree over the stages.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ_q <= '0;
      end else if (flush) begin
         occ_q <= '0;
      end else if (in_xfer && !out_xfer) begin
         occ_q <= occ_q + OW'(1);
      end else if (out_xfer && !in_xfer) begin
         occ_q <= occ_q - OW'(1);
      end
   end

   assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipe_regs.sv
// Directed bench for pipe_regs (WIDTH=8, LANES=2, DEPTH=3): vector table plus async reset sequence.
module tb_pipe_regs;

   logic       clk;
   logic       reset;
   logic       flush;
   logic       in_valid;
   logic [7:0] in_data [1:0];
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data [1:0];
   logic       out_ready;
`ifdef PIPE_REGS_OCC_EN
   logic [1:0] occupancy;
`endif

   int tests;
   int fails;

   pipe_regs #(.WIDTH(8), .LANES(2), .DEPTH(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
`ifdef PIPE_REGS_OCC_EN
      ,
      .occupancy (occupancy)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       flush;
      logic       iv;
      logic [7:0] d1;
      logic [7:0] d0;
      logic       ordy;
      logic       e_ir;
      logic       e_ov;
      logic       chk_d;
      logic [7:0] e1;
      logic [7:0] e0;
      logic [1:0] e_occ;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic f, input logic iv, input logic [7:0] d1,
                               input logic [7:0] d0, input logic ordy, input logic e_ir,
                               input logic e_ov, input logic chk_d, input logic [7:0] e1,
                               input logic [7:0] e0, input logic [1:0] e_occ);
      vec_t v;
      v.flush = f;    v.iv = iv;     v.d1 = d1;       v.d0 = d0;  v.ordy = ordy;
      v.e_ir  = e_ir; v.e_ov = e_ov; v.chk_d = chk_d; v.e1 = e1;  v.e0 = e0;
      v.e_occ = e_occ;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_occ(input string name, input logic [1:0] exp);
`ifdef PIPE_REGS_OCC_EN
      check(name, {30'd0, occupancy}, {30'd0, exp});
`else
      if (exp > 2'd3) $display("unreachable %s", name);
`endif
   endtask

   task automatic drive(input logic f, input logic iv, input logic [7:0] d1,
                        input logic [7:0] d0, input logic ordy);
      flush      = f;
      in_valid   = iv;
      in_data[1] = d1;
      in_data[0] = d0;
      out_ready  = ordy;
   endtask

   function automatic logic [7:0] inv(input int k);
      logic [7:0] b;
      b = 8'(k);
      return ~b;
   endfunction

   initial begin
      int lat;
      tests = 0;
      fails = 0;
      reset = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

      // Single item A5/3C: visible after three edges, then drained.
      add(0, 1, 8'hA5, 8'h3C, 1,  1, 0, 0, 8'h00, 8'h00, 2'd0);
      add(0, 0, 8'h00, 8'h00, 1,  1, 0, 0, 8'h00, 8'h00, 2'd1);
      add(0, 0, 8'h00, 8'h00, 1,  1, 0, 0, 8'h00, 8'h00, 2'd1);
      add(0, 0, 8'h00, 8'h00, 1,  1, 1, 1, 8'hA5, 8'h3C, 2'd1);
      add(0, 0, 8'h00, 8'h00, 1,  1, 0, 0, 8'h00, 8'h00, 2'd0);
      // Stream 1..8 with out_ready held high.
      for (int k = 1; k <= 8; k++) begin
         add(0, 1, 8'(k), inv(k), 1, 1, (k >= 4), (k >= 4), 8'(k - 3), inv(k - 3),
             (k <= 3) ? 2'(k - 1) : 2'd3);
      end
      for (int j = 6; j <= 8; j++) begin
         add(0, 0, 8'h00, 8'h00, 1, 1, 1, 1, 8'(j), inv(j), 2'(3 - (j - 6)));
      end
      // Backpressure: fill, stall with 4th pending, then one-cycle pass-through.
      add(0, 1, 8'h21, inv(8'h21), 0,  1, 0, 0, 8'h00, 8'h00, 2'd0);
      add(0, 1, 8'h22, inv(8'h22), 0,  1, 0, 0, 8'h00, 8'h00, 2'd1);
      add(0, 1, 8'h23, inv(8'h23), 0,  1, 0, 0, 8'h00, 8'h00, 2'd2);
      add(0, 1, 8'h24, inv(8'h24), 0,  0, 1, 1, 8'h21, inv(8'h21), 2'd3);
      add(0, 1, 8'h24, inv(8'h24), 0,  0, 1, 1, 8'h21, inv(8'h21), 2'd3);
      add(0, 1, 8'h24, inv(8'h24), 1,  1, 1, 1, 8'h21, inv(8'h21), 2'd3);
      add(0, 0, 8'h00, 8'h00,      0,  0, 1, 1, 8'h22, inv(8'h22), 2'd3);
      // Drain one, then flush with two items held and an input offered.
      add(0, 0, 8'h00, 8'h00,      1,  1, 1, 1, 8'h22, inv(8'h22), 2'd3);
      add(1, 1, 8'h99, 8'h66,      1,  0, 0, 0, 8'h00, 8'h00, 2'd2);
      for (int j = 0; j < 4; j++) begin
         add(0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00, 2'd0);
      end

      // Reset state, held across clock edges.
      repeat (2) @(negedge clk);
      #1;
      check("rst_hold_ov", {31'd0, out_valid}, 32'd0);
      check("rst_hold_d1", {24'd0, out_data[1]}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_ov", {31'd0, out_valid}, 32'd0);
      check("rst_ir", {31'd0, in_ready}, 32'd1);
      check("rst_d1", {24'd0, out_data[1]}, 32'd0);
      check("rst_d0", {24'd0, out_data[0]}, 32'd0);
      check_occ("rst_occ", 2'd0);

      // Table: inputs applied at negedge, outputs checked 1 time unit later.
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].flush, vecs[i].iv, vecs[i].d1, vecs[i].d0, vecs[i].ordy);
         #1;
         check($sformatf("v%0d_ir", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
         check($sformatf("v%0d_ov", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
         if (vecs[i].chk_d) begin
            check($sformatf("v%0d_d1", i), {24'd0, out_data[1]}, {24'd0, vecs[i].e1});
            check($sformatf("v%0d_d0", i), {24'd0, out_data[0]}, {24'd0, vecs[i].e0});
         end
         check_occ($sformatf("v%0d_occ", i), vecs[i].e_occ);
      end

      // Fill the pipe with out_ready low, then reset asynchronously between edges.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(1'b0, 1'b1, 8'(8'h31 + k), 8'h00, 1'b0);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      #1;
      check("full_ov", {31'd0, out_valid}, 32'd1);
      check("full_ir", {31'd0, in_ready}, 32'd0);
      #1;
      reset = 1'b0;
      #1;
      check("async_ov", {31'd0, out_valid}, 32'd0);
      check("async_ir", {31'd0, in_ready}, 32'd1);
      check("async_d1", {24'd0, out_data[1]}, 32'd0);
      check_occ("async_occ", 2'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      drive(1'b0, 1'b1, 8'h77, 8'h88, 1'b1);
      #1;
      check("post_rst_ir", {31'd0, in_ready}, 32'd1);
      check("post_rst_ov", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      lat = 1;
      #1;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         #1;
         lat++;
      end
      check("post_rst_lat", 32'(lat), 32'd3);
      check("post_rst_d1", {24'd0, out_data[1]}, 32'h77);
      check("post_rst_d0", {24'd0, out_data[0]}, 32'h88);
      @(negedge clk);
      #1;
      check("post_rst_empty", {31'd0, out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_regs.md
PIPE_REGS -- requirements
Module: pipe_regs

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning bits per lane.
REQ-002 SHALL have parameter LANES, default 1, meaning parallel lanes per stage.
REQ-003 SHALL have parameter DEPTH, default 1, meaning pipeline stages; legal range DEPTH >= 1.
REQ-004 clk  input  1  rising-edge clock; the block's only clock.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 flush  input  1  synchronous clear of all stage contents.
REQ-007 in_valid  input  1  upstream item present.
REQ-008 in_data  input  WIDTH x LANES (unpacked array [LANES-1:0])  upstream item.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 out_valid  output  1  item present at final stage.
REQ-011 out_data  output  WIDTH x LANES  final-stage item.
REQ-012 out_ready  input  1  downstream accepts item this cycle.
REQ-013 occupancy  output  $clog2(DEPTH+1)  count of valid stages (only with PIPE_REGS_OCC_EN).

Function
REQ-014 Each stage k (0..DEPTH-1) SHALL hold valid_q[k] and data_q[k][LANES]; stage 0 is the input stage, stage DEPTH-1 drives out_valid/out_data directly.
REQ-015 Advance terms SHALL be adv[DEPTH-1] = !valid_q[DEPTH-1] | out_ready and adv[k] = !valid_q[k] | adv[k+1]; bubbles collapse.
REQ-016 in_ready SHALL equal adv[0] & !flush.
REQ-017 On a clock edge with adv[k] and no flush, stage k SHALL load valid from stage k-1 (stage 0: in_valid), and data only when that source is valid; otherwise data holds.
REQ-018 Input transfer SHALL occur when in_valid & in_ready; output transfer when out_valid & out_ready.
REQ-019 Latency from accept into an empty pipe to out_valid SHALL be exactly DEPTH cycles; sustained throughput SHALL be one item per cycle.
REQ-020 Item order SHALL be preserved; no item SHALL be duplicated or dropped except by flush.
REQ-021 out_valid SHALL be valid_q[DEPTH-1] & !flush; no output transfer occurs in a flush cycle.
REQ-022 flush high at an edge SHALL clear every valid_q to 0; data_q holds; any in_valid that cycle is dropped (in_ready=0).
REQ-023 Full (all valid) with out_ready=0: in_ready SHALL be 0 and all contents hold.
REQ-024 Full with out_ready=1: simultaneous input and output transfer SHALL occur; occupancy unchanged.
REQ-025 out_data SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-026 While reset=0, all valid_q SHALL be 0 and all data_q SHALL be 0, asynchronously, independent of clk.
REQ-027 Reset outputs: out_valid=0, out_data=0, in_ready=1 (flush low), occupancy=0.
REQ-028 Reset mid-stream SHALL discard all in-flight items; first edge after deassertion behaves as empty pipe.

Configuration
REQ-029 Macro PIPE_REGS_OCC_EN defined: occupancy port SHALL exist, registered, equal to popcount(valid_q) after every edge; +1 on input-only transfer, -1 on output-only, 0 after flush/reset.
REQ-030 Macro PIPE_REGS_OCC_EN undefined: occupancy port and counter SHALL be absent; all other behaviour identical.

Verification (WIDTH=8, LANES=2, DEPTH=3)
REQ-031 Reset low then high, no stimulus -> out_valid=0, out_data={0,0}, in_ready=1, occupancy=0.
REQ-032 Single item {8'hA5,8'h3C} accepted at edge 0, out_ready=1 -> out_valid=1 with {A5,3C} after edge 2 (3 cycles), occupancy 1 then 0 after transfer.
REQ-033 Stream 0x01..0x08 with out_ready=1 -> outputs 0x01..0x08 in order, one per cycle after 3-cycle fill.
REQ-034 out_ready=0, push 4 items -> first 3 accepted, in_ready=0 on 4th, occupancy=3; out_ready=1 one cycle -> 4th accepted same edge, occupancy stays 3.
REQ-035 Pipe holding 2 items, flush=1 one cycle with in_valid=1 -> in_ready=0, out_valid=0, occupancy=0 next edge, dropped input never appears.
REQ-036 reset pulsed low mid-stream while full -> out_valid falls immediately without a clock edge; next accepted item emerges after 3 cycles.
